// File: rtl/osd_hex_field_reader.sv
`default_nettype none
// ============================================================================
// Module      : osd_hex_field_reader
// Description : Fetches NDIGITS ASCII hex chars from the OSD text buffer via a
//               shared req/gnt read port and returns the decoded value.
// Revision    : 1.0 - initial release
// ============================================================================
module osd_hex_field_reader #(
    parameter int COLS    = 16,
    parameter int ADDR_W  = 7,
    parameter int NDIGITS = 2,
    parameter int RD_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [3:0]           linea,
    input  logic [4:0]           columna,
    output logic                 busy,
    output logic                 rd_req,
    input  logic                 rd_gnt,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [7:0]           rd_data,
    output logic [4*NDIGITS-1:0] value,
    output logic                 valid,
    output logic                 err,
    output logic [NDIGITS-1:0]   err_pos
);
    localparam int VAL_W  = 4 * NDIGITS;
    localparam int IDX_W  = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int WCNT_W = $clog2(RD_LAT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NDIGITS - 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_CAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [VAL_W-1:0]    value_q, value_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [NDIGITS-1:0]  err_pos_q, err_pos_d;
    logic [VAL_W-1:0]    acc_q, acc_d;
    logic [NDIGITS-1:0]  errv_q, errv_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [ADDR_W-1:0]   base_addr;
    logic [4:0]          dec;

    // Returns {invalid, nibble}; invalid chars decode to nibble 0.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'b1_0000;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b0, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            r = {1'b0, c[3:0] + 4'd9};
        end
        return r;
    endfunction

    always_comb begin
        base_addr = ADDR_W'(linea) * ADDR_W'(COLS) + ADDR_W'(columna);
        dec       = hex_decode(rd_data);
        state_d   = state_q;
        busy_d    = busy_q;
        rd_req_d  = rd_req_q;
        rd_addr_d = rd_addr_q;
        value_d   = value_q;
        valid_d   = 1'b0;
        err_d     = err_q;
        err_pos_d = err_pos_q;
        acc_d     = acc_q;
        errv_d    = errv_q;
        idx_d     = idx_q;
        wcnt_d    = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_REQ;
                    busy_d    = 1'b1;
                    rd_req_d  = 1'b1;
                    rd_addr_d = base_addr;
                    acc_d     = '0;
                    errv_d    = '0;
                    idx_d     = '0;
                end
            end
            S_REQ: begin
                if (rd_gnt) begin
                    if (RD_LAT == 1) begin
                        state_d = S_CAP;
                    end else begin
                        state_d = S_WAIT;
                        wcnt_d  = WCNT_W'(1);
                    end
                end
            end
            S_WAIT: begin
                // Losing the grant mid-read invalidates the pending data.
                if (!rd_gnt) begin
                    state_d = S_REQ;
                end else if (wcnt_q == WAIT_LAST) begin
                    state_d = S_CAP;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_CAP: begin
                acc_d = (acc_q << 4) | VAL_W'(dec[3:0]);
                if (dec[4]) begin
                    errv_d[idx_q] = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d   = S_DONE;
                    rd_req_d  = 1'b0;
                    valid_d   = 1'b1;
                    value_d   = acc_d;
                    err_pos_d = errv_d;
                    err_d     = |errv_d;
                end else begin
                    state_d   = S_REQ;
                    idx_d     = idx_q + 1'b1;
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            err_pos_q <= '0;
            acc_q     <= '0;
            errv_q    <= '0;
            idx_q     <= '0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            rd_req_q  <= rd_req_d;
            rd_addr_q <= rd_addr_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            err_pos_q <= err_pos_d;
            acc_q     <= acc_d;
            errv_q    <= errv_d;
            idx_q     <= idx_d;
            wcnt_q    <= wcnt_d;
        end
    end

    assign busy    = busy_q;
    assign rd_req  = rd_req_q;
    assign rd_addr = rd_addr_q;
    assign value   = value_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign err_pos = err_pos_q;

endmodule
`default_nettype wire
